bfly_issue_ctrl: RTL and testbench

- Request-side issue controller placed between NumIn masters and the first stage of the radix-2 butterfly network.
- Each port has a one-entry holding slot. When the network refuses a request, the slot captures it and replays it until it is granted.
- Each port counts how long its slot has been waiting and raises a priority flag once that wait reaches MaxWait. Network arbitration uses the flag as a starvation hint.
- Each port regenerates a response-valid strobe aligned with the network's one-cycle read-data latency.

---
 rtl/bfly_issue_if.sv | 14 +
 rtl/bfly_issue_ctrl.sv | 102 ++++++++++
 tb/tb_bfly_issue_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/bfly_issue_if.sv
// bfly_issue_if: request/grant bus between a master (or issue controller) and the butterfly network.
interface bfly_issue_if #(
    parameter int NumIn     = 8,
    parameter int AddWidth  = 4,
    parameter int DataWidth = 32
);
    logic [NumIn-1:0]                req;
    logic [NumIn-1:0]                gnt;
    logic [NumIn-1:0]                wen;
    logic [NumIn-1:0][AddWidth-1:0]  add;
    logic [NumIn-1:0][DataWidth-1:0] data;
    modport master (output req, add, wen, data, input gnt);
    modport slave (input req, add, wen, data, output gnt);
endinterface

// File: rtl/bfly_issue_ctrl.sv
// bfly_issue_ctrl: per-port replay slot, starvation hint and rvalid regeneration for the butterfly network.
// Optional per-port grant/stall/starve counters are enabled with `define BFLY_ISSUE_STATS_EN.
module bfly_issue_ctrl #(
    parameter int NumIn     = 8,
    parameter int AddWidth  = 4,
    parameter int DataWidth = 32,
    parameter int MaxWait   = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    bfly_issue_if.slave      mst,
    bfly_issue_if.master     net,
    output logic [NumIn-1:0] rvalid_o,
    output logic [NumIn-1:0] prio_o,
    output logic             busy_o
`ifdef BFLY_ISSUE_STATS_EN
    ,
    input  logic                   stat_clr_i,
    output logic [NumIn-1:0][15:0] stat_grant_o,
    output logic [NumIn-1:0][15:0] stat_stall_o,
    output logic [NumIn-1:0][15:0] stat_starve_o
`endif
);
    localparam int CW = $clog2(MaxWait + 1);
    typedef enum logic [1:0] {IDLE, PEND, STARVE} state_e;
    logic [NumIn-1:0] busy;
    assign busy_o = |busy;
    for (genvar i = 0; i < NumIn; i++) begin : g_port
        state_e               state;
        logic [CW-1:0]        cnt;
        logic [AddWidth-1:0]  slot_add;
        logic                 slot_wen;
        logic [DataWidth-1:0] slot_data;
        logic                 idle, fire, rvalid, prio;
        assign idle         = state == IDLE;
        assign net.req[i]   = ~rst_i & (~idle | mst.req[i]);
        assign net.add[i]   = idle ? mst.add[i] : slot_add;
        assign net.wen[i]   = idle ? mst.wen[i] : slot_wen;
        assign net.data[i]  = idle ? mst.data[i] : slot_data;
        // A replayed slot is never acknowledged to the master; it keeps holding its next request.
        assign mst.gnt[i]   = ~rst_i & idle & net.gnt[i];
        assign fire         = net.req[i] & net.gnt[i];
        assign busy[i]      = ~idle;
        assign rvalid_o[i]  = rvalid;
        assign prio_o[i]    = prio;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state     <= IDLE;
                cnt       <= '0;
                slot_add  <= '0;
                slot_wen  <= 1'b0;
                slot_data <= '0;
                rvalid    <= 1'b0;
                prio      <= 1'b0;
            end else begin
                rvalid <= fire;
                if (idle) begin
                    if (mst.req[i] & ~net.gnt[i]) begin
                        state     <= PEND;
                        cnt       <= '0;
                        slot_add  <= mst.add[i];
                        slot_wen  <= mst.wen[i];
                        slot_data <= mst.data[i];
                    end
                end else if (net.gnt[i]) begin
                    state <= IDLE;
                    cnt   <= '0;
                    prio  <= 1'b0;
                end else if (state == PEND) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(MaxWait - 1)) begin
                        state <= STARVE;
                        prio  <= 1'b1;
                    end
                end
            end
        end
`ifdef BFLY_ISSUE_STATS_EN
        logic [15:0] n_grant, n_stall, n_starve;
        logic        starve_in;
        assign starve_in        = state == PEND && ~net.gnt[i] && cnt == CW'(MaxWait - 1);
        assign stat_grant_o[i]  = n_grant;
        assign stat_stall_o[i]  = n_stall;
        assign stat_starve_o[i] = n_starve;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                n_grant  <= '0;
                n_stall  <= '0;
                n_starve <= '0;
            end else if (stat_clr_i) begin
                n_grant  <= '0;
                n_stall  <= '0;
                n_starve <= '0;
            end else begin
                if (fire && ~&n_grant) n_grant <= n_grant + 1'b1;
                if (~idle && ~&n_stall) n_stall <= n_stall + 1'b1;
                if (starve_in && ~&n_starve) n_starve <= n_starve + 1'b1;
            end
        end
`endif
    end
endmodule

// File: tb/tb_bfly_issue_ctrl.sv
// tb_bfly_issue_ctrl: directed stimulus checked against a pending/denial-count model of each port.
`define CHK(n, a, e) chk(n, 256'(a), 256'(e))
module tb_bfly_issue_ctrl;
    localparam int N = 8, AW = 4, DW = 32, MW = 7;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    bfly_issue_if #(.NumIn(N), .AddWidth(AW), .DataWidth(DW)) m_if ();
    bfly_issue_if #(.NumIn(N), .AddWidth(AW), .DataWidth(DW)) n_if ();
    logic [N-1:0] rvalid, prio;
    logic         busy;
`ifdef BFLY_ISSUE_STATS_EN
    logic [N-1:0][15:0] s_grant, s_stall, s_starve;
`endif
    bfly_issue_ctrl #(.NumIn(N), .AddWidth(AW), .DataWidth(DW), .MaxWait(MW)) dut (
        .clk_i(clk), .rst_i(rst), .mst(m_if), .net(n_if),
        .rvalid_o(rvalid), .prio_o(prio), .busy_o(busy)
`ifdef BFLY_ISSUE_STATS_EN
        , .stat_clr_i(1'b0), .stat_grant_o(s_grant), .stat_stall_o(s_stall), .stat_starve_o(s_starve)
`endif
    );
    int errors = 0, checks = 0;
    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    bit             pend [N];
    int             den  [N];
    logic [AW-1:0]  sa   [N];
    logic           sw   [N];
    logic [DW-1:0]  sd   [N];
    bit   [N-1:0]   rv;
    function automatic logic e_req(int i);
        return !rst && (pend[i] || m_if.req[i]);
    endfunction
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                pend[i] <= 1'b0;
                den[i]  <= 0;
            end
            rv <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                rv[i] <= e_req(i) && n_if.gnt[i];
                if (!pend[i]) begin
                    if (m_if.req[i] && !n_if.gnt[i]) begin
                        pend[i] <= 1'b1;
                        den[i]  <= 0;
                        sa[i]   <= m_if.add[i];
                        sw[i]   <= m_if.wen[i];
                        sd[i]   <= m_if.data[i];
                    end
                end else if (n_if.gnt[i]) pend[i] <= 1'b0;
                else den[i] <= den[i] + 1;
            end
        end
    end
    always @(negedge clk) begin : cmp
        logic [N-1:0]    er, eg, ew, ep;
        logic [N*AW-1:0] ea;
        logic [N*DW-1:0] ed;
        logic            eb;
        eb = 1'b0;
        for (int i = 0; i < N; i++) begin
            er[i]           = e_req(i);
            eg[i]           = !rst && !pend[i] && n_if.gnt[i];
            ew[i]           = pend[i] ? sw[i] : m_if.wen[i];
            ea[i*AW +: AW]  = pend[i] ? sa[i] : m_if.add[i];
            ed[i*DW +: DW]  = pend[i] ? sd[i] : m_if.data[i];
            ep[i]           = pend[i] && den[i] >= MW;
            eb              = eb | pend[i];
        end
        checks += 8;
        if (n_if.req !== er) begin errors++; $display("FAIL req_o: got %0h expected %0h", n_if.req, er); end
        if (m_if.gnt !== eg) begin errors++; $display("FAIL gnt_o: got %0h expected %0h", m_if.gnt, eg); end
        if (n_if.wen !== ew) begin errors++; $display("FAIL wen_o: got %0h expected %0h", n_if.wen, ew); end
        if (n_if.add !== ea) begin errors++; $display("FAIL add_o: got %0h expected %0h", n_if.add, ea); end
        if (n_if.data !== ed) begin errors++; $display("FAIL data_o: got %0h expected %0h", n_if.data, ed); end
        if (prio !== ep) begin errors++; $display("FAIL prio_o: got %0h expected %0h", prio, ep); end
        if (rvalid !== rv) begin errors++; $display("FAIL rvalid_o: got %0h expected %0h", rvalid, rv); end
        if (busy !== eb) begin errors++; $display("FAIL busy_o: got %0h expected %0h", busy, eb); end
    end
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    logic [15:0] tbl [12] = '{16'h0000, 16'hFFFF, 16'hFF00, 16'h0F00, 16'hA5F0, 16'h00FF,
                              16'h3C3C, 16'hFFC3, 16'h0000, 16'h5A00, 16'h00A5, 16'hFFFF};
    initial begin
        m_if.req = '0; m_if.add = '0; m_if.wen = '0; m_if.data = '0; n_if.gnt = '0;
        repeat (2) @(negedge clk);
        `CHK("reset_busy", busy, 1'b0);
        `CHK("reset_req", n_if.req, 8'h00);
        cyc();
        rst = 1'b0;
        cyc();
        m_if.req[0] = 1'b1; m_if.add[0] = 4'h3; m_if.data[0] = 32'hDEADBEEF; m_if.wen[0] = 1'b1; n_if.gnt[0] = 1'b1;
        @(negedge clk);
        `CHK("p0_gnt", m_if.gnt[0], 1'b1);
        `CHK("p0_add", n_if.add[0], 4'h3);
        `CHK("p0_data", n_if.data[0], 32'hDEADBEEF);
        `CHK("p0_busy", busy, 1'b0);
        cyc();
        m_if.req[0] = 1'b0; n_if.gnt[0] = 1'b0;
        @(negedge clk);
        `CHK("p0_rvalid", rvalid[0], 1'b1);
        cyc();
        @(negedge clk);
        `CHK("p0_rvalid_once", rvalid[0], 1'b0);
        cyc();
        m_if.req[1] = 1'b1; m_if.add[1] = 4'h5; m_if.data[1] = 32'h11111111; m_if.wen[1] = 1'b0;
        @(negedge clk);
        `CHK("p1_req", n_if.req[1], 1'b1);
        `CHK("p1_gnt0", m_if.gnt[1], 1'b0);
        for (int k = 0; k < 2; k++) begin
            cyc();
            m_if.add[1] = 4'hA; m_if.data[1] = 32'h22222222; m_if.wen[1] = 1'b1;
            @(negedge clk);
            `CHK("p1_hold_add", n_if.add[1], 4'h5);
            `CHK("p1_hold_data", n_if.data[1], 32'h11111111);
            `CHK("p1_busy", busy, 1'b1);
        end
        cyc();
        n_if.gnt[1] = 1'b1;
        @(negedge clk);
        `CHK("p1_gnt_slot", m_if.gnt[1], 1'b0);
        `CHK("p1_wen_slot", n_if.wen[1], 1'b0);
        cyc();
        m_if.req[1] = 1'b0; n_if.gnt[1] = 1'b0;
        @(negedge clk);
        `CHK("p1_rvalid", rvalid[1], 1'b1);
        `CHK("p1_idle", busy, 1'b0);
        cyc();
        m_if.req[2] = 1'b1; m_if.add[2] = 4'h7;
        @(negedge clk);
        for (int k = 1; k <= MW; k++) begin
            cyc();
            m_if.req[2] = 1'b0;
            @(negedge clk);
            `CHK("p2_prio_low", prio[2], 1'b0);
        end
        cyc();
        @(negedge clk);
        `CHK("p2_prio_high", prio[2], 1'b1);
        cyc();
        n_if.gnt[2] = 1'b1;
        @(negedge clk);
        `CHK("p2_prio_hold", prio[2], 1'b1);
        `CHK("p2_req", n_if.req[2], 1'b1);
        cyc();
        n_if.gnt[2] = 1'b0;
        @(negedge clk);
        `CHK("p2_prio_drop", prio[2], 1'b0);
        `CHK("p2_busy_drop", busy, 1'b0);
        `CHK("p2_rvalid", rvalid[2], 1'b1);
        cyc();
        m_if.req[3] = 1'b1; m_if.add[3] = 4'h9; m_if.data[3] = 32'h33333333;
        @(negedge clk);
        repeat (MW) cyc();
        m_if.req[3] = 1'b0;
        cyc();
        `CHK("p3_prio", prio[3], 1'b1);
        #2 rst = 1'b1;
        #1;
        `CHK("p3_rst_req", n_if.req[3], 1'b0);
        `CHK("p3_rst_prio", prio[3], 1'b0);
        `CHK("p3_rst_busy", busy, 1'b0);
        #2 rst = 1'b0;
        cyc();
        n_if.gnt[3] = 1'b1;
        @(negedge clk);
        cyc();
        n_if.gnt[3] = 1'b0;
        @(negedge clk);
        `CHK("p3_no_rvalid", rvalid, 8'h00);
        cyc();
        n_if.gnt = 8'hFF;
        @(negedge clk);
        `CHK("spur_req", n_if.req, 8'h00);
        cyc();
        n_if.gnt = 8'h00;
        @(negedge clk);
        `CHK("spur_rvalid", rvalid, 8'h00);
        `CHK("spur_busy", busy, 1'b0);
        cyc();
        m_if.req[4] = 1'b1; m_if.add[4] = 4'h1; m_if.data[4] = 32'h44440001;
        @(negedge clk);
        cyc();
        m_if.add[4] = 4'h2; m_if.data[4] = 32'h44440002; n_if.gnt[4] = 1'b1;
        @(negedge clk);
        `CHK("p4_slot_add", n_if.add[4], 4'h1);
        cyc();
        @(negedge clk);
        `CHK("p4_pass_add", n_if.add[4], 4'h2);
        `CHK("p4_pass_gnt", m_if.gnt[4], 1'b1);
        `CHK("p4_rvalid1", rvalid[4], 1'b1);
        cyc();
        m_if.req[4] = 1'b0; n_if.gnt[4] = 1'b0;
        @(negedge clk);
        `CHK("p4_rvalid2", rvalid[4], 1'b1);
        cyc();
        @(negedge clk);
        `CHK("p4_rvalid_end", rvalid[4], 1'b0);
        for (int t = 0; t < 12; t++) begin
            cyc();
            m_if.req = tbl[t][15:8];
            n_if.gnt = tbl[t][7:0];
            for (int i = 0; i < N; i++) begin
                m_if.add[i]  = AW'(t + i);
                m_if.data[i] = {16'(t), 16'(i)};
                m_if.wen[i]  = 1'((t + i) % 2);
            end
            @(negedge clk);
        end
        cyc();
        m_if.req = '0; n_if.gnt = '1;
        @(negedge clk);
        cyc();
        n_if.gnt = '0;
        @(negedge clk);
        `CHK("final_busy", busy, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
